gray_ptr_tx: RTL and testbench

- Write-domain transmitter feeding a clock-domain-crossing synchronizer.
- Maintains a binary FIFO write pointer and publishes it as a registered Gray-coded value, so that at most one bit changes per update.
- Decodes the synchronized read pointer coming back from the other domain and uses it to produce registered full and occupancy (level) flags.
- Monitors the returning pointer for Gray violations (more than one bit changed between samples), so metastability corruption is detectable in simulation and silicon.

---
 rtl/gray_ptr_tx.sv | 79 +++++++
 tb/tb_gray_ptr_tx.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/gray_ptr_tx.sv
// rtl/gray_ptr_tx.sv - write-side FIFO pointer publisher with Gray-coded output, full/level flags and read-pointer Gray checker
module gray_ptr_tx #(
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  w_clk_i,
    input  logic                  w_rstn_i,
    input  logic                  w_inc_i,
    output logic                  w_wen_o,
    output logic [ADDR_WIDTH-1:0] w_addr_o,
    output logic [ADDR_WIDTH:0]   w_ptr_gray_o,
    input  logic [ADDR_WIDTH:0]   r_ptr_gray_sync_i,
    output logic                  w_full_o,
    output logic [ADDR_WIDTH:0]   w_level_o,
    output logic                  gray_err_o,
    output logic [CNT_WIDTH-1:0]  gray_err_cnt_o
);
    localparam int P = ADDR_WIDTH + 1;

    logic [P-1:0] w_bin;
    logic [P-1:0] bin_next;
    logic [P-1:0] gray_next;
    logic [P-1:0] r_bin;
    logic [P-1:0] full_gray;
    logic [P-1:0] r_gray_q;
    logic [P-1:0] r_diff;
    logic         acc;
    logic         viol;

    assign acc       = w_inc_i & ~w_full_o;
    assign w_wen_o   = acc;
    assign w_addr_o  = w_bin[ADDR_WIDTH-1:0];
    assign bin_next  = w_bin + {{(P-1){1'b0}}, acc};
    assign gray_next = bin_next ^ (bin_next >> 1);

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray terms that is the read pointer with its top two bits inverted.
    assign full_gray = {~r_ptr_gray_sync_i[P-1], ~r_ptr_gray_sync_i[P-2],
                        r_ptr_gray_sync_i[P-3:0]};

    always_comb begin
        r_bin = '0;
        for (int i = 0; i < P; i++) begin
            r_bin[i] = ^(r_ptr_gray_sync_i >> i);
        end
    end

    // More than one bit set in the sample-to-sample difference.
    assign r_diff = r_ptr_gray_sync_i ^ r_gray_q;
    assign viol   = (r_diff & (r_diff - 1'b1)) != '0;

    always_ff @(posedge w_clk_i or negedge w_rstn_i) begin
        if (!w_rstn_i) begin
            w_bin        <= '0;
            w_ptr_gray_o <= '0;
            w_full_o     <= 1'b0;
            w_level_o    <= '0;
        end else begin
            w_bin        <= bin_next;
            w_ptr_gray_o <= gray_next;
            w_full_o     <= (gray_next == full_gray);
            w_level_o    <= bin_next - r_bin;
        end
    end

    always_ff @(posedge w_clk_i or negedge w_rstn_i) begin
        if (!w_rstn_i) begin
            r_gray_q       <= '0;
            gray_err_o     <= 1'b0;
            gray_err_cnt_o <= '0;
        end else begin
            r_gray_q   <= r_ptr_gray_sync_i;
            gray_err_o <= viol;
            if (viol && (gray_err_cnt_o != {CNT_WIDTH{1'b1}})) begin
                gray_err_cnt_o <= gray_err_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_gray_ptr_tx.sv
// tb/tb_gray_ptr_tx.sv - directed and randomized checks of gray_ptr_tx against a count-based reference model
module tb_gray_ptr_tx;
    localparam int AW = 4;
    localparam int CW = 2;
    localparam int P  = AW + 1;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          inc = 1'b0;
    logic [P-1:0]  r = '0;
    logic          w_wen_o;
    logic [AW-1:0] w_addr_o;
    logic [P-1:0]  w_ptr_gray_o;
    logic          w_full_o;
    logic [P-1:0]  w_level_o;
    logic          gray_err_o;
    logic [CW-1:0] gray_err_cnt_o;

    gray_ptr_tx #(.ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .w_clk_i(clk),
        .w_rstn_i(rstn),
        .w_inc_i(inc),
        .w_wen_o(w_wen_o),
        .w_addr_o(w_addr_o),
        .w_ptr_gray_o(w_ptr_gray_o),
        .r_ptr_gray_sync_i(r),
        .w_full_o(w_full_o),
        .w_level_o(w_level_o),
        .gray_err_o(gray_err_o),
        .gray_err_cnt_o(gray_err_cnt_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model state: write count modulo 32, registered flags, last sampled read pointer.
    int m_bin, m_level, m_rq, m_cnt, m_gray;
    bit m_full, m_err;
    int rb;

    function automatic int to_gray(int b);
        return (b ^ (b >> 1)) & 31;
    endfunction

    function automatic int from_gray(int g);
        for (int b = 0; b < 32; b++) begin
            if (to_gray(b) == g) return b;
        end
        return 0;
    endfunction

    function automatic int ones(int v);
        int n = 0;
        for (int k = 0; k < 32; k++) n += (v >> k) & 1;
        return n;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_bin = 0; m_level = 0; m_rq = 0; m_cnt = 0; m_gray = 0;
        m_full = 0; m_err = 0;
    endtask

    // Called at a negedge: drive, check combinational outputs, clock, check registers.
    task automatic step(input bit i, input int rv);
        int rbin;
        bit acc;
        inc = i;
        r = rv[P-1:0];
        #1;
        chk("wen", {31'b0, w_wen_o}, {31'b0, i && !m_full});
        chk("addr", {28'b0, w_addr_o}, m_bin % 16);
        @(posedge clk);
        acc = i && !m_full;
        if (acc) m_bin = (m_bin + 1) % 32;
        m_gray = to_gray(m_bin);
        rbin = from_gray(rv & 31);
        m_level = (m_bin - rbin + 32) % 32;
        m_full = (m_level == 16);
        m_err = ones((rv ^ m_rq) & 31) > 1;
        if (m_err && m_cnt < 3) m_cnt++;
        m_rq = rv & 31;
        @(negedge clk);
        chk("gray", {27'b0, w_ptr_gray_o}, m_gray);
        chk("full", {31'b0, w_full_o}, {31'b0, m_full});
        chk("level", {27'b0, w_level_o}, m_level);
        chk("err", {31'b0, gray_err_o}, {31'b0, m_err});
        chk("cnt", {30'b0, gray_err_cnt_o}, m_cnt);
    endtask

    initial begin
        model_reset();
        rb = 0;
        #12;
        chk("rst_gray", {27'b0, w_ptr_gray_o}, 0);
        chk("rst_full", {31'b0, w_full_o}, 0);
        chk("rst_level", {27'b0, w_level_o}, 0);
        chk("rst_cnt", {30'b0, gray_err_cnt_o}, 0);
        @(negedge clk);
        rstn = 1'b1;

        // Fill from empty: 16 accepts, then a refused 17th write.
        for (int k = 0; k < 16; k++) step(1'b1, 0);
        chk("fill_full", {31'b0, w_full_o}, 1);
        chk("fill_level", {27'b0, w_level_o}, 16);
        chk("fill_gray", {27'b0, w_ptr_gray_o}, 32'h18);
        step(1'b1, 0);
        chk("fill_hold", {27'b0, w_ptr_gray_o}, 32'h18);

        // Read pointer jumps to bin 4 (two-bit change is also a Gray violation).
        rb = 4;
        step(1'b0, to_gray(rb));
        chk("rd_full", {31'b0, w_full_o}, 0);
        chk("rd_level", {27'b0, w_level_o}, 12);
        step(1'b1, to_gray(rb));
        chk("rd_level13", {27'b0, w_level_o}, 13);

        // Legal random traffic until the write pointer reaches bin 31, then drain reads.
        for (int k = 0; k < 400 && m_bin != 31; k++) begin
            if (rb != m_bin && $urandom_range(0, 1) == 1) rb = (rb + 1) % 32;
            step($urandom_range(0, 3) != 0, to_gray(rb));
        end
        chk("wrap_reach", m_bin, 31);
        for (int k = 0; k < 40 && rb != 31; k++) begin
            rb = (rb + 1) % 32;
            step(1'b0, to_gray(rb));
        end
        step(1'b1, to_gray(rb));
        chk("wrap_gray", {27'b0, w_ptr_gray_o}, 0);
        chk("wrap_addr", {28'b0, w_addr_o}, 0);
        chk("wrap_full", {31'b0, w_full_o}, 0);
        chk("wrap_level", {27'b0, w_level_o}, 1);

        // Asynchronous reset in the middle of a write burst.
        step(1'b1, to_gray(rb));
        step(1'b1, to_gray(rb));
        inc = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("arst_gray", {27'b0, w_ptr_gray_o}, 0);
        chk("arst_addr", {28'b0, w_addr_o}, 0);
        chk("arst_full", {31'b0, w_full_o}, 0);
        chk("arst_level", {27'b0, w_level_o}, 0);
        chk("arst_err", {31'b0, gray_err_o}, 0);
        chk("arst_cnt", {30'b0, gray_err_cnt_o}, 0);
        model_reset();
        rb = 0;
        r = '0;
        @(negedge clk);
        rstn = 1'b1;
        step(1'b1, 0);
        chk("post_rst_gray", {27'b0, w_ptr_gray_o}, 1);

        // Gray checker: 0->3 violates, 3->2 is legal, then repeated violations saturate.
        step(1'b0, 3);
        chk("chk_pulse", {31'b0, gray_err_o}, 1);
        chk("chk_cnt1", {30'b0, gray_err_cnt_o}, 1);
        step(1'b0, 2);
        chk("chk_legal", {31'b0, gray_err_o}, 0);
        chk("chk_cnt_hold", {30'b0, gray_err_cnt_o}, 1);
        step(1'b0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1'b0, (k % 2 == 0) ? 3 : 0);
            chk("sat_pulse", {31'b0, gray_err_o}, 1);
        end
        chk("sat_cnt", {30'b0, gray_err_cnt_o}, 3);

        // Random traffic with occasional corrupted read pointers.
        rb = 0;
        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) begin
                rb = $urandom_range(0, 31);
            end else if (rb != m_bin && $urandom_range(0, 1) == 1) begin
                rb = (rb + 1) % 32;
            end
            step($urandom_range(0, 1) == 1, to_gray(rb));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
